// File: rtl/current_sense_adc_pkg.sv
// Shared definitions for the motor-phase current-sense ADC reader:
// frame engine state encoding, default timing constants and frame length helper.
package current_sense_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } frame_state_e;

    localparam int DEF_CLK_DIV       = 8;
    localparam int DEF_SAMPLE_PERIOD = 1600;
    localparam int DEF_LEAD_BITS     = 3;
    localparam int DEF_DATA_BITS     = 12;
    localparam int DEF_AVG_LOG2      = 2;
    localparam int DEF_OFFSET_RESET  = 2048;

    // Number of CLK cycles chip select stays low for one conversion:
    // one setup slot, two slots per SCK pulse, one hold slot.
    function automatic int frame_len_cycles(input int clk_div, input int n_bits);
        return (2 * n_bits + 2) * clk_div;
    endfunction

endpackage

// File: rtl/current_sense_adc_spi_adc_frame.sv
// One SPI conversion frame: CS low, setup slot, N SCK pulses sampling MISO on
// the rising SCK edge, hold slot, then CS high with the captured code and a
// one-cycle done strobe.
module spi_adc_frame
    import current_sense_adc_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int LEAD_BITS = DEF_LEAD_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 miso_i,
    output logic                 cs_o,
    output logic                 sck_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] raw_o
);

    localparam int N_BITS = LEAD_BITS + DATA_BITS;
    localparam int DW     = $clog2(CLK_DIV + 1);
    localparam int BW     = $clog2(N_BITS + 1);

    frame_state_e         state_q;
    logic [DW-1:0]        div_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] sr_q;
    logic [DATA_BITS-1:0] raw_q;
    logic                 cs_q;
    logic                 sck_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_last_s;

    // End of the current CLK_DIV-long slot.
    always_comb begin
        div_last_s = (div_q == DW'(CLK_DIV - 1));
    end

    // Frame sequencer: slot timing, SCK generation, bit capture and result load.
    // Lead bits simply fall off the top of the shift register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            raw_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_q  <= 1'b1;
                    sck_q <= 1'b1;
                    div_q <= '0;
                    bit_q <= '0;
                    if (start_i) begin
                        state_q <= ST_SETUP;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (div_last_s) begin
                        div_q   <= '0;
                        sck_q   <= 1'b0;
                        state_q <= ST_SHIFT;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (div_last_s) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            sr_q  <= {sr_q[DATA_BITS-2:0], miso_i};
                        end else if (bit_q == BW'(N_BITS - 1)) begin
                            state_q <= ST_HOLD;
                        end else begin
                            sck_q <= 1'b0;
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_HOLD: begin
                    if (div_last_s) begin
                        div_q   <= '0;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        raw_q   <= sr_q;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_q    <= 1'b1;
                    sck_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cs_o   = cs_q;
    assign sck_o  = sck_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign raw_o  = raw_q;

endmodule

// File: rtl/current_sense_adc.sv
// Periodic current-sense ADC reader: schedules conversions, averages a
// power-of-two group of samples, removes a calibratable zero offset and
// presents a signed current word with a one-cycle valid strobe.
module current_sense_adc
    import current_sense_adc_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int LEAD_BITS     = DEF_LEAD_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int AVG_LOG2      = DEF_AVG_LOG2,
    parameter int OFFSET_RESET  = DEF_OFFSET_RESET
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    output logic                        CS_CLK,
    output logic                        CS,
    input  logic                        CS_MISO,
    input  logic                        calibrate,
    output logic signed [DATA_BITS:0]   current,
    output logic                        current_valid,
    output logic [DATA_BITS-1:0]        raw,
    output logic                        busy
);

    localparam int PW    = $clog2(SAMPLE_PERIOD);
    localparam int AW    = DATA_BITS + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam int GROUP = 1 << AVG_LOG2;

    logic [PW-1:0]               period_q, period_d;
    logic                        start_s;
    logic                        frame_done_s;
    logic [DATA_BITS-1:0]        raw_s;

    logic [AW-1:0]               acc_q, acc_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [DATA_BITS-1:0]        offset_q, offset_d;
    logic                        cal_pending_q, cal_pending_d;
    logic signed [DATA_BITS:0]   current_q, current_d;
    logic                        valid_q, valid_d;

    logic [AW-1:0]               acc_sum_s;
    logic [DATA_BITS-1:0]        avg_s;
    logic                        group_done_s;

    spi_adc_frame #(
        .CLK_DIV   (CLK_DIV),
        .LEAD_BITS (LEAD_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_frame (
        .clk_i     (CLK),
        .reset_n_i (reset_n),
        .start_i   (start_s),
        .miso_i    (CS_MISO),
        .cs_o      (CS),
        .sck_o     (CS_CLK),
        .busy_o    (busy),
        .done_o    (frame_done_s),
        .raw_o     (raw_s)
    );

    // Conversion scheduler: free-running period counter, start on its last count.
    always_comb begin
        start_s = (period_q == PW'(SAMPLE_PERIOD - 1));
        if (start_s) begin
            period_d = '0;
        end else begin
            period_d = period_q + PW'(1);
        end
    end

    // Averaging, offset subtraction and calibration bookkeeping.
    // The result uses the running sum including the sample that just finished.
    always_comb begin
        acc_sum_s    = acc_q + AW'(raw_s);
        avg_s        = acc_sum_s[AW-1:AVG_LOG2];
        group_done_s = frame_done_s && (cnt_q == CW'(GROUP - 1));

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        offset_d  = offset_q;
        current_d = current_q;
        valid_d   = 1'b0;

        if (frame_done_s) begin
            if (group_done_s) begin
                acc_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
                if (cal_pending_q) begin
                    offset_d  = avg_s;
                    current_d = '0;
                end else begin
                    current_d = $signed({1'b0, avg_s}) - $signed({1'b0, offset_q});
                end
            end else begin
                acc_d = acc_sum_s;
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            acc_d = acc_q;
        end

        // A pending request is consumed by the next result; new requests are
        // only accepted while nothing is pending.
        if (cal_pending_q) begin
            cal_pending_d = !group_done_s;
        end else begin
            cal_pending_d = calibrate;
        end
    end

    // State registers for scheduler, accumulator, offset and result.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            period_q      <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            offset_q      <= DATA_BITS'(OFFSET_RESET);
            cal_pending_q <= 1'b0;
            current_q     <= '0;
            valid_q       <= 1'b0;
        end else begin
            period_q      <= period_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            offset_q      <= offset_d;
            cal_pending_q <= cal_pending_d;
            current_q     <= current_d;
            valid_q       <= valid_d;
        end
    end

    assign current       = current_q;
    assign current_valid = valid_q;
    assign raw           = raw_s;

endmodule

// File: tb/tb_current_sense_adc.sv
// Bench for current_sense_adc: SPI ADC model, directed groups of samples with
// hand-computed expected current words in a scoreboard queue, and a monitor
// that checks every current_valid strobe against it.
module tb_current_sense_adc;
    import current_sense_adc_pkg::*;

    localparam int FRAME_LEN = frame_len_cycles(DEF_CLK_DIV, DEF_LEAD_BITS + DEF_DATA_BITS);

    logic               CLK = 1'b0;
    logic               reset_n = 1'b0;
    logic               CS_CLK;
    logic               CS;
    logic               CS_MISO = 1'b0;
    logic               calibrate = 1'b0;
    logic signed [12:0] current;
    logic               current_valid;
    logic [11:0]        raw;
    logic               busy;

    logic [11:0] adc_code = 12'd0;
    logic [2:0]  lead_val = 3'b000;
    logic [14:0] adc_word;
    int          adc_idx = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int mon_cyc = 0;
    int strobe_cnt = 0;
    int last_cyc = 0;
    int prev_cyc = 0;

    current_sense_adc dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .CS_CLK        (CS_CLK),
        .CS            (CS),
        .CS_MISO       (CS_MISO),
        .calibrate     (calibrate),
        .current       (current),
        .current_valid (current_valid),
        .raw           (raw),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    // ADC model: word restarts on CS fall, next bit presented on each SCK fall.
    always @(negedge CS or negedge CS_CLK) begin
        if (!CS && CS_CLK) begin
            adc_idx = 0;
        end else if (!CS && adc_idx < 15) begin
            adc_word = {lead_val, adc_code};
            CS_MISO  = adc_word[14 - adc_idx];
            adc_idx++;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Monitor: every strobe must match the oldest expected result.
    always @(negedge CLK) begin
        mon_cyc++;
        if (current_valid) begin
            strobe_cnt++;
            prev_cyc = last_cyc;
            last_cyc = mon_cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got current %0d, expected no strobe", current);
            end else begin
                check("current", longint'(current), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_cs_fall();
        int k;
        for (k = 0; k < 2 * DEF_SAMPLE_PERIOD + 300; k++) begin
            @(posedge CLK); #1;
            if (!CS) break;
        end
        if (CS) timeout("cs_fall");
    endtask

    task automatic wait_cs_rise();
        int k;
        for (k = 0; k < FRAME_LEN + 16; k++) begin
            @(posedge CLK); #1;
            if (CS) break;
        end
        if (!CS) timeout("cs_rise");
    endtask

    task automatic pulse_cal();
        calibrate = 1'b1;
        @(posedge CLK); #1;
        calibrate = 1'b0;
    endtask

    task automatic run_frame(input int code, input logic [2:0] lead);
        adc_code = 12'(code);
        lead_val = lead;
        wait_cs_fall();
        wait_cs_rise();
    endtask

    task automatic run_group(input int c0, input int c1, input int c2, input int c3,
                             input logic [2:0] lead, input int expv,
                             input bit cal0, input bit cal1);
        int codes[4];
        codes = '{c0, c1, c2, c3};
        exp_q.push_back(expv);
        for (int i = 0; i < 4; i++) begin
            if ((i == 0 && cal0) || (i == 1 && cal1)) pulse_cal();
            run_frame(codes[i], lead);
        end
    endtask

    initial begin
        int cyc;
        int low_cyc;
        int rises;
        int first_fall;
        int falls;
        int strobes_before;
        logic prev_sck;

        // Reset values
        reset_n = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("rst_CS", longint'(CS), 1);
        check("rst_CS_CLK", longint'(CS_CLK), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_current", longint'(current), 0);
        check("rst_valid", longint'(current_valid), 0);
        check("rst_raw", longint'(raw), 0);

        // First frame timing, constant code 2304
        adc_code = 12'd2304;
        lead_val = 3'b000;
        exp_q.push_back(256);
        reset_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 2 * DEF_SAMPLE_PERIOD; k++) begin
            @(posedge CLK); #1;
            cyc++;
            if (!CS) break;
        end
        check("cs_fall_cycle", longint'(cyc), longint'(DEF_SAMPLE_PERIOD));
        check("busy_in_frame", longint'(busy), 1);
        low_cyc = 0;
        rises = 0;
        first_fall = -1;
        prev_sck = CS_CLK;
        for (int k = 0; k < FRAME_LEN + 16; k++) begin
            @(posedge CLK); #1;
            low_cyc++;
            if (!prev_sck && CS_CLK) rises++;
            if (prev_sck && !CS_CLK && first_fall < 0) first_fall = low_cyc;
            prev_sck = CS_CLK;
            if (CS) break;
        end
        check("cs_low_cycles", longint'(low_cyc), 256);
        check("sck_rises", longint'(rises), 15);
        check("first_sck_fall", longint'(first_fall), 8);
        check("raw_2304", longint'(raw), 2304);
        check("busy_after_frame", longint'(busy), 0);
        for (int i = 0; i < 3; i++) run_frame(2304, 3'b000);
        check("valid_at_cs_rise", longint'(current_valid), 0);
        @(posedge CLK); #1;
        check("valid_next_cycle", longint'(current_valid), 1);
        check("current_value_2304", longint'(current), 256);
        @(posedge CLK); #1;
        check("valid_one_cycle", longint'(current_valid), 0);
        check("current_holds", longint'(current), 256);

        // Truncating average, plus strobe interval
        run_group(100, 101, 102, 104, 3'b000, -1947, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("strobe_interval", longint'(last_cyc - prev_cyc), 6400);

        // Extremes with ones in the lead bits
        run_group(4095, 4095, 4095, 4095, 3'b111, 2047, 1'b0, 1'b0);
        check("raw_4095", longint'(raw), 4095);
        run_group(0, 0, 0, 0, 3'b111, -2048, 1'b0, 1'b0);
        check("raw_0_lead_ones", longint'(raw), 0);

        // Calibration: second pulse while pending has no effect
        run_group(2100, 2100, 2100, 2100, 3'b000, 0, 1'b1, 1'b1);
        run_group(2100, 2100, 2100, 2100, 3'b000, 0, 1'b0, 1'b0);
        run_group(2110, 2110, 2110, 2110, 3'b000, 10, 1'b0, 1'b0);
        // Pulse lands in the result cycle: applies to the following group
        pulse_cal();
        run_group(2120, 2120, 2120, 2120, 3'b000, 0, 1'b0, 1'b0);

        // Reset during the 7th SCK pulse of the 3rd frame of a group
        run_frame(2200, 3'b000);
        run_frame(2200, 3'b000);
        adc_code = 12'd2200;
        wait_cs_fall();
        falls = 0;
        prev_sck = CS_CLK;
        for (int k = 0; k < FRAME_LEN; k++) begin
            @(posedge CLK); #1;
            if (prev_sck && !CS_CLK) falls++;
            prev_sck = CS_CLK;
            if (falls == 7) break;
        end
        check("falls_before_reset", longint'(falls), 7);
        repeat (3) @(posedge CLK);
        #1;
        strobes_before = strobe_cnt;
        reset_n = 1'b0;
        @(posedge CLK); #1;
        check("midreset_CS", longint'(CS), 1);
        check("midreset_CS_CLK", longint'(CS_CLK), 1);
        repeat (9) @(posedge CLK);
        #1;
        reset_n = 1'b1;
        check("midreset_raw", longint'(raw), 0);
        exp_q.push_back(256);
        for (int i = 0; i < 3; i++) run_frame(2304, 3'b000);
        repeat (3) @(posedge CLK);
        #1;
        check("no_strobe_3_frames", longint'(strobe_cnt), longint'(strobes_before));
        run_frame(2304, 3'b000);
        repeat (3) @(posedge CLK);
        #1;
        check("strobe_after_4_frames", longint'(strobe_cnt), longint'(strobes_before + 1));
        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
